// File: rtl/layer_scheduler.sv
// ---------------------------------------------------------------------------
// layer_scheduler
// Sequences one neural-network layer evaluation over a single shared MAC:
// for every neuron it clears the accumulator, issues N_INPUTS multiply-
// accumulate terms, requests activation, then strobes the result write.
// State advances on the falling edge of clk to line up with the layer
// datapath. All outputs are decoded from registered state and indices only.
//
// Ports
//   clk        in   clock (state updates on falling edge)
//   rst        in   asynchronous active-low reset
//   start      in   begin one layer evaluation (honoured only in IDLE)
//   abort      in   synchronous cancel back to IDLE, beats every ack
//   mac_ack    in   MAC accepted the current term (ISSUE only)
//   act_ack    in   activation unit finished (ACT only)
//   busy       out  high in every state except IDLE
//   mac_clear  out  accumulator clear, CLEAR state
//   mac_req    out  multiply-accumulate request, ISSUE state
//   mac_last   out  current term is the last of the neuron
//   act_req    out  activation request, ACT state
//   wr_en      out  result write strobe, WRITE state
//   neuron_idx out  current neuron / write address
//   input_idx  out  current input / weight index
//   done       out  end-of-layer pulse, DONE state
//
// state | meaning
// IDLE  | waiting for start, indices held at 0
// CLEAR | one-cycle accumulator clear for the current neuron
// ISSUE | mac_req held until mac_ack, one term per ack
// ACT   | act_req held until act_ack
// WRITE | one-cycle result write at neuron_idx
// DONE  | one-cycle end-of-layer pulse
// ---------------------------------------------------------------------------
module layer_scheduler #(
    parameter int N_NEURONS = 2,
    parameter int N_INPUTS  = 2,
    parameter int IW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mac_ack,
    input  logic          act_ack,
    output logic          busy,
    output logic          mac_clear,
    output logic          mac_req,
    output logic          mac_last,
    output logic          act_req,
    output logic          wr_en,
    output logic [IW-1:0] neuron_idx,
    output logic [IW-1:0] input_idx,
    output logic          done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_ACT   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [IW-1:0] LAST_N = IW'(N_NEURONS - 1);
    localparam logic [IW-1:0] LAST_I = IW'(N_INPUTS - 1);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] nidx_q, nidx_d;
    logic [IW-1:0] iidx_q, iidx_d;

    always_comb begin
        state_d = state_q;
        nidx_d  = nidx_q;
        iidx_d  = iidx_q;
        // abort outranks every ack, so it is resolved before the state decode
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            nidx_d  = '0;
            iidx_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        nidx_d  = '0;
                        iidx_d  = '0;
                    end
                end
                S_CLEAR: state_d = S_ISSUE;
                S_ISSUE: begin
                    if (mac_ack) begin
                        if (iidx_q == LAST_I) begin
                            state_d = S_ACT;
                        end else begin
                            iidx_d = iidx_q + IW'(1);
                        end
                    end
                end
                S_ACT: begin
                    if (act_ack) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (nidx_q == LAST_N) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLEAR;
                        nidx_d  = nidx_q + IW'(1);
                        iidx_d  = '0;
                    end
                end
                S_DONE: begin
                    // indices return to 0 so IDLE always looks the same
                    state_d = S_IDLE;
                    nidx_d  = '0;
                    iidx_d  = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    nidx_d  = '0;
                    iidx_d  = '0;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            nidx_q  <= '0;
            iidx_q  <= '0;
        end else begin
            state_q <= state_d;
            nidx_q  <= nidx_d;
            iidx_q  <= iidx_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign mac_clear  = (state_q == S_CLEAR);
    assign mac_req    = (state_q == S_ISSUE);
    assign mac_last   = (state_q == S_ISSUE) && (iidx_q == LAST_I);
    assign act_req    = (state_q == S_ACT);
    assign wr_en      = (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign neuron_idx = nidx_q;
    assign input_idx  = iidx_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_layer_scheduler
// Two scheduler instances: default sizing (2 neurons x 2 inputs) and a
// 3 neurons x 1 input variant. Each layer run is planned up front: random
// ack stall lengths per term/activation are chosen, and from that plan the
// expected per-cycle output picture and the input drive are listed in
// queues. The DUT updates on falling edges; the bench samples and drives on
// rising edges.
// ---------------------------------------------------------------------------
module tb_layer_scheduler;

    logic clk = 1'b1;
    logic rst = 1'b1;
    logic start1 = 0, abort1 = 0, mack1 = 0, aack1 = 0;
    logic start3 = 0, abort3 = 0, mack3 = 0, aack3 = 0;

    logic b1, c1, r1, l1, a1, w1, d1;
    logic [7:0] n1, i1;
    logic b3, c3, r3, l3, a3, w3, d3;
    logic [7:0] n3, i3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [22:0] exp_q[$];
    logic [3:0]  drv_q[$];

    always #5 clk = ~clk;

    layer_scheduler #(.N_NEURONS(2), .N_INPUTS(2), .IW(8)) dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .mac_ack(mack1), .act_ack(aack1),
        .busy(b1), .mac_clear(c1), .mac_req(r1), .mac_last(l1),
        .act_req(a1), .wr_en(w1), .neuron_idx(n1), .input_idx(i1), .done(d1));

    layer_scheduler #(.N_NEURONS(3), .N_INPUTS(1), .IW(8)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .mac_ack(mack3), .act_ack(aack3),
        .busy(b3), .mac_clear(c3), .mac_req(r3), .mac_last(l3),
        .act_req(a3), .wr_en(w3), .neuron_idx(n3), .input_idx(i3), .done(d3));

    // {busy, clear, req, last, act, wr, done, neuron[7:0], input[7:0]}
    function automatic logic [22:0] obs(input bit sel);
        if (sel) return {b3, c3, r3, l3, a3, w3, d3, n3, i3};
        return {b1, c1, r1, l1, a1, w1, d1, n1, i1};
    endfunction

    function automatic logic [22:0] mk(input logic b, c, r, l, a, w, d,
                                       input int n, input int i);
        return {b, c, r, l, a, w, d, 8'(n), 8'(i)};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive(input bit sel, input logic [3:0] v);
        if (sel) {start3, abort3, mack3, aack3} = v;
        else     {start1, abort1, mack1, aack1} = v;
    endtask

    // Plan one layer and check it cycle by cycle.
    // smax: max ack stall cycles; junk: random start while busy;
    // cack: acks held 1 outside waits; stall5: 5-cycle mac_ack stall on term 0;
    // abort_n: neuron whose ACT is aborted (-1: none)
    task automatic run_layer(input string nm, input bit sel, input int nn,
                             input int ni, input int smax, input bit junk,
                             input bit cack, input bit stall5, input int abort_n);
        int st;
        int wr_cnt, done_cnt, exp_wr, exp_done;
        logic [22:0] o;
        logic ja, jb;
        exp_q.delete();
        drv_q.delete();
        ja = cack ? 1'b1 : rb();
        jb = cack ? 1'b1 : rb();
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0));
        drv_q.push_back({1'b1, 1'b0, ja, jb});
        begin : plan
            for (int n = 0; n < nn; n++) begin
                ja = cack ? 1'b1 : rb();
                jb = cack ? 1'b1 : rb();
                exp_q.push_back(mk(1,1,0,0,0,0,0,n,0));
                drv_q.push_back({junk & rb(), 1'b0, ja, jb});
                for (int i = 0; i < ni; i++) begin
                    st = (stall5 && n == 0 && i == 0) ? 5 : $urandom_range(0, smax);
                    for (int s = 0; s <= st; s++) begin
                        jb = cack ? 1'b1 : rb();
                        exp_q.push_back(mk(1,0,1,(i == ni-1),0,0,0,n,i));
                        drv_q.push_back({junk & rb(), 1'b0, (s == st), jb});
                    end
                end
                st = $urandom_range(0, smax);
                for (int s = 0; s <= st; s++) begin
                    ja = cack ? 1'b1 : rb();
                    exp_q.push_back(mk(1,0,0,0,1,0,0,n,ni-1));
                    if (n == abort_n && s == st) begin
                        drv_q.push_back({junk & rb(), 1'b1, ja, 1'b1});
                        exp_q.push_back(mk(0,0,0,0,0,0,0,0,0));
                        drv_q.push_back(4'b0);
                        disable plan;
                    end
                    drv_q.push_back({junk & rb(), 1'b0, ja, (s == st)});
                end
                ja = cack ? 1'b1 : rb();
                jb = cack ? 1'b1 : rb();
                exp_q.push_back(mk(1,0,0,0,0,1,0,n,ni-1));
                drv_q.push_back({junk & rb(), 1'b0, ja, jb});
            end
            ja = cack ? 1'b1 : rb();
            jb = cack ? 1'b1 : rb();
            exp_q.push_back(mk(1,0,0,0,0,0,1,nn-1,ni-1));
            drv_q.push_back({junk & rb(), 1'b0, ja, jb});
            exp_q.push_back(mk(0,0,0,0,0,0,0,0,0));
            drv_q.push_back(4'b0);
        end
        wr_cnt = 0;
        done_cnt = 0;
        foreach (exp_q[k]) begin
            @(posedge clk);
            o = obs(sel);
            wr_cnt += int'(o[17]);
            done_cnt += int'(o[16]);
            n_cmp++;
            if (o !== exp_q[k]) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", nm, k, o, exp_q[k]);
            end
            drive(sel, drv_q[k]);
        end
        exp_wr = (abort_n < 0) ? nn : abort_n;
        exp_done = (abort_n < 0) ? 1 : 0;
        n_cmp++;
        if (wr_cnt !== exp_wr) begin
            n_bad++;
            $display("FAIL %s wr_en count: got %0d expected %0d", nm, wr_cnt, exp_wr);
        end
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_bad++;
            $display("FAIL %s done count: got %0d expected %0d", nm, done_cnt, exp_done);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs(0) !== 23'b0) begin
            n_bad++;
            $display("FAIL reset dut: got %h expected 0", obs(0));
        end
        n_cmp++;
        if (obs(1) !== 23'b0) begin
            n_bad++;
            $display("FAIL reset dut3: got %h expected 0", obs(1));
        end
        repeat (2) @(posedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        run_layer("basic", 0, 2, 2, 0, 0, 1, 0, -1);
    endtask

    task automatic test_stall();
        run_layer("stall", 0, 2, 2, 0, 0, 0, 1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) run_layer("random", 0, 2, 2, 3, 1, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_layer("b2b_a", 0, 2, 2, 0, 1, 1, 0, -1);
        run_layer("b2b_b", 0, 2, 2, 1, 1, 0, 0, -1);
    endtask

    task automatic test_abort();
        run_layer("abort_act1", 0, 2, 2, 0, 0, 1, 0, 1);
        run_layer("abort_act0", 0, 2, 2, 2, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        drive(0, 4'b1000);
        @(posedge clk);
        drive(0, 4'b0000);
        @(posedge clk);
        n_cmp++;
        if (obs(0) !== mk(1,0,1,0,0,0,0,0,0)) begin
            n_bad++;
            $display("FAIL rst_mid pre: got %h expected %h", obs(0), mk(1,0,1,0,0,0,0,0,0));
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs(0) !== 23'b0) begin
            n_bad++;
            $display("FAIL rst_mid async: got %h expected 0", obs(0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            n_cmp++;
            if (obs(0) !== 23'b0) begin
                n_bad++;
                $display("FAIL rst_mid idle %0d: got %h expected 0", k, obs(0));
            end
        end
    endtask

    task automatic test_n3();
        run_layer("n3_const", 1, 3, 1, 0, 0, 1, 0, -1);
        run_layer("n3_rand", 1, 3, 1, 3, 1, 0, 0, -1);
        run_layer("n3_abort", 1, 3, 1, 1, 0, 0, 0, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_basic();
        test_n3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 2, neurons per layer sharing one MAC (range 1..255).
REQ-002 SHALL have parameter N_INPUTS, default 2, inputs per neuron (range 1..255).
REQ-003 SHALL have parameter IW, default 8, width of index outputs.
REQ-004 SHALL have port clk  input  1  clock; all state updates on falling edge, matching the layer datapath.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin one layer evaluation.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current evaluation.
REQ-008 SHALL have port mac_ack  input  1  MAC accepted the current input term.
REQ-009 SHALL have port act_ack  input  1  activation unit finished.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port mac_clear  output  1  one-cycle accumulator clear.
REQ-012 SHALL have port mac_req  output  1  request one multiply-accumulate.
REQ-013 SHALL have port mac_last  output  1  marks final term of a neuron.
REQ-014 SHALL have port act_req  output  1  request activation of the accumulator.
REQ-015 SHALL have port wr_en  output  1  one-cycle result write strobe.
REQ-016 SHALL have port neuron_idx  output  IW  current neuron; also the write address.
REQ-017 SHALL have port input_idx  output  IW  current input/weight index.
REQ-018 SHALL have port done  output  1  one-cycle end-of-layer pulse.

Function
REQ-019 SHALL implement states IDLE, CLEAR, ISSUE, ACT, WRITE, DONE, one state per falling edge.
REQ-020 SHALL, in IDLE, move to CLEAR when start=1 at an edge, with neuron_idx=0 and input_idx=0; start in any other state is ignored.
REQ-021 SHALL assert mac_clear only in CLEAR and always move CLEAR -> ISSUE after one cycle.
REQ-022 SHALL hold mac_req=1 throughout ISSUE; an edge with mac_ack=1 completes the term.
REQ-023 SHALL drive mac_last=1 in ISSUE iff input_idx==N_INPUTS-1; mac_last is otherwise 0.
REQ-024 SHALL, on a completed term, increment input_idx and remain in ISSUE if it was not the last term; otherwise go to ACT.
REQ-025 SHALL keep input_idx and mac_req stable while mac_ack=0, with no timeout.
REQ-026 SHALL hold act_req=1 throughout ACT and move to WRITE on an edge with act_ack=1.
REQ-027 SHALL assert wr_en for exactly the one WRITE cycle, with neuron_idx valid as the address.
REQ-028 SHALL, after WRITE, go to DONE if neuron_idx==N_NEURONS-1; otherwise increment neuron_idx, clear input_idx to 0, and go to CLEAR.
REQ-029 SHALL assert done for the single DONE cycle, then return to IDLE; start during DONE is ignored.
REQ-030 SHALL ignore mac_ack outside ISSUE and act_ack outside ACT.
REQ-031 SHALL, when abort=1 at an edge in any non-IDLE state, go to IDLE with indices 0 and without done or wr_en; abort has priority over every ack.
REQ-032 SHALL give neuron_idx and input_idx wrap-free behaviour: they never exceed N_NEURONS-1 and N_INPUTS-1 respectively.
REQ-033 SHALL drive all outputs as Moore functions of state and indices, with no combinational path from inputs.

Reset
REQ-034 SHALL, while rst=0, immediately force IDLE, neuron_idx=0, input_idx=0, and all 1-bit outputs=0, regardless of clk.
REQ-035 SHALL, on rst asserted mid-evaluation, discard progress, and after release need a new start.

Verification
REQ-036 Defaults; start=1 for one edge, mac_ack=act_ack=1 constant -> busy rises, wr_en pulses with neuron_idx=0 then 1, done is high exactly in the 11th cycle after start is sampled, then IDLE.
REQ-037 mac_ack held 0 for 5 cycles at input_idx=0 -> mac_req stays 1, input_idx stays 0, mac_last=0; after ack, input_idx=1 and mac_last=1.
REQ-038 start pulsed again while busy -> no effect on indices; exactly one done per layer; wr_en count equals N_NEURONS (2).
REQ-039 abort=1 during ACT of neuron 1 with act_ack=1 at the same edge -> next state IDLE, no wr_en, no done, busy=0.
REQ-040 rst driven low between clock edges during ISSUE -> outputs 0 and indices 0 with no clock edge; after release, idle until start.
REQ-041 N_NEURONS=3, N_INPUTS=1 -> mac_last=1 on every mac_req, mac_clear pulses 3 times, done after neuron_idx=2 is written.
